// File: rtl/vga_timing_pkg.sv
// Shared raster timing definitions for the VGA timing generator.
// Holds the default 640x480@60 mode, a mode descriptor type and
// small helpers used to size counters and coordinate buses.
package vga_timing_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  // Line length (pixels) or frame height (lines) of one axis.
  function automatic int total(input int active, input int fp,
                               input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // $clog2 clamped to one bit so a degenerate one-pixel axis still
  // produces a legal bus width.
  function automatic int pos_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping up-counter that advances on enable and
// flags its terminal count. Used once per line (H) and once per frame (V).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = 800
) (
  input  logic                      pixelClk,
  input  logic                      rst,
  input  logic                      en,
  output logic [pos_w(TOTAL)-1:0]   count,
  output logic                      wrap
);

  localparam int              CW   = pos_w(TOTAL);
  localparam logic [CW-1:0]   LAST = CW'(TOTAL - 1);

  logic [CW-1:0] count_q, count_d;

  // wrap is the unqualified terminal count; the caller gates it with its
  // own enable so the V axis can chain off the H wrap.
  assign wrap  = (count_q == LAST);
  assign count = count_q;

  // Next count: hold, step, or return to 0 after the last position.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  // Position register.
  always_ff @(posedge pixelClk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator. Produces registered sync,
// active-area coordinates, line/frame/vblank strobes and a completed-frame
// counter. Every output is decoded from the pre-increment (h,v) on the same
// enabled edge, so outputs lag the counters by one enabled cycle.
// rst is asynchronous; its release is expected to be synchronised upstream.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_640X480_60.h_active,
  parameter int H_FP     = VGA_640X480_60.h_fp,
  parameter int H_SYNC   = VGA_640X480_60.h_sync,
  parameter int H_BP     = VGA_640X480_60.h_bp,
  parameter int V_ACTIVE = VGA_640X480_60.v_active,
  parameter int V_FP     = VGA_640X480_60.v_fp,
  parameter int V_SYNC   = VGA_640X480_60.v_sync,
  parameter int V_BP     = VGA_640X480_60.v_bp,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int FRAME_W  = 8
) (
  input  logic                         pixelClk,
  input  logic                         rst,
  input  logic                         pixelEn,
  output logic [pos_w(H_ACTIVE)-1:0]   xPos,
  output logic [pos_w(V_ACTIVE)-1:0]   yPos,
  output logic                         pixelActive,
  output logic                         hSync,
  output logic                         vSync,
  output logic                         lineStart,
  output logic                         frameStart,
  output logic                         vblankStart,
  output logic [FRAME_W-1:0]           frameCount
);

  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = pos_w(H_TOTAL);
  localparam int VW      = pos_w(V_TOTAL);
  localparam int XW      = pos_w(H_ACTIVE);
  localparam int YW      = pos_w(V_ACTIVE);

  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          H_ASSERT   = 1'(H_POL);
  localparam logic          V_ASSERT   = 1'(V_POL);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || FRAME_W < 1) begin : g_bad_size
    $fatal(1, "vga_timing_gen: every timing parameter must be >= 1");
  end
  if (!(H_POL == 0 || H_POL == 1) || !(V_POL == 0 || V_POL == 1)) begin : g_bad_pol
    $fatal(1, "vga_timing_gen: H_POL and V_POL must be 0 or 1");
  end

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic          h_wrap;
  logic          v_wrap;
  logic          v_en;

  assign v_en = pixelEn & h_wrap;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_axis (
    .pixelClk (pixelClk),
    .rst      (rst),
    .en       (pixelEn),
    .count    (h_count),
    .wrap     (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_axis (
    .pixelClk (pixelClk),
    .rst      (rst),
    .en       (v_en),
    .count    (v_count),
    .wrap     (v_wrap)
  );

  logic [XW-1:0]      x_pos_q, x_pos_d;
  logic [YW-1:0]      y_pos_q, y_pos_d;
  logic               active_q, active_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic               vblank_start_q, vblank_start_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;

  // Decode the current (pre-increment) raster position into output values.
  always_comb begin
    active_d       = (h_count < H_ACT_END) && (v_count < V_ACT_END);
    x_pos_d        = active_d ? h_count[XW-1:0] : '0;
    y_pos_d        = active_d ? v_count[YW-1:0] : '0;
    hsync_d        = ((h_count >= H_SYNC_BEG) && (h_count <= H_SYNC_END)) ? H_ASSERT : ~H_ASSERT;
    vsync_d        = ((v_count >= V_SYNC_BEG) && (v_count <= V_SYNC_END)) ? V_ASSERT : ~V_ASSERT;
    line_start_d   = (h_count == '0);
    frame_start_d  = (h_count == '0) && (v_count == '0);
    vblank_start_d = (h_count == '0) && (v_count == V_ACT_END);
    frame_count_d  = frame_count_q;
    if (v_en && v_wrap) begin
      frame_count_d = frame_count_q + 1'b1;
    end
  end

  // Output registers: load on enabled edges only, so strobes hold while idle.
  always_ff @(posedge pixelClk or posedge rst) begin
    if (rst) begin
      x_pos_q        <= '0;
      y_pos_q        <= '0;
      active_q       <= 1'b0;
      hsync_q        <= ~H_ASSERT;
      vsync_q        <= ~V_ASSERT;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_count_q  <= '0;
    end else if (pixelEn) begin
      x_pos_q        <= x_pos_d;
      y_pos_q        <= y_pos_d;
      active_q       <= active_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign xPos        = x_pos_q;
  assign yPos        = y_pos_q;
  assign pixelActive = active_q;
  assign hSync       = hsync_q;
  assign vSync       = vsync_q;
  assign lineStart   = line_start_q;
  assign frameStart  = frame_start_q;
  assign vblankStart = vblank_start_q;
  assign frameCount  = frame_count_q;

endmodule
